// File: rtl/fifo_tmr_pkg.sv
// rtl/fifo_tmr_pkg.sv - shared constants, scrub FSM states and majority vote for the TMR FIFO
package fifo_tmr_pkg;

  localparam int DEFAULT_WIDTH_SIZE   = 64;
  localparam int DEFAULT_ADDRESS_SIZE = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_WB,
    S_ADV,
    S_DONE
  } scrub_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fifo_tmr_scrubber_vote.sv
// rtl/fifo_tmr_scrubber_vote.sv - combinational bitwise vote of three copies with mismatch/fatal flags
module tmr_vote_check
  import fifo_tmr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH_SIZE
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_voted,
  output logic             o_mismatch,
  output logic             o_fatal
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_vote
    assign o_voted[i] = maj3(i_a[i], i_b[i], i_c[i]);
  end

  assign o_mismatch = (i_a != o_voted) || (i_b != o_voted) || (i_c != o_voted);
  // Pairwise-distinct copies leave no trustworthy majority for the word.
  assign o_fatal    = (i_a != i_b) && (i_b != i_c) && (i_a != i_c);

endmodule

// File: rtl/fifo_tmr_scrubber.sv
// rtl/fifo_tmr_scrubber.sv - TMR memory scrub controller and write-port arbiter (FIFO writes win)
// Optional macro SCRUB_PERIODIC_EN adds an internal start every SCRUB_PERIOD idle cycles.
module fifo_tmr_scrubber
  import fifo_tmr_pkg::*;
#(
  parameter int WIDTH_SIZE   = DEFAULT_WIDTH_SIZE,
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int COUNT_WIDTH  = 16,
  parameter int SCRUB_PERIOD = 1000000
) (
  input  logic                    write_clk,
  input  logic                    write_reset,
  input  logic                    write_enable,
  input  logic                    write_full,
  input  logic [ADDRESS_SIZE-1:0] write_address,
  input  logic [WIDTH_SIZE-1:0]   write_data,
  input  logic                    scrub_start,
  input  logic                    scrub_abort,
  output logic [ADDRESS_SIZE-1:0] scrub_address,
  input  logic [WIDTH_SIZE-1:0]   scrub_data1,
  input  logic [WIDTH_SIZE-1:0]   scrub_data2,
  input  logic [WIDTH_SIZE-1:0]   scrub_data3,
  output logic                    mem_write_enable,
  output logic                    mem_write_full,
  output logic [ADDRESS_SIZE-1:0] mem_write_address,
  output logic [WIDTH_SIZE-1:0]   mem_write_data,
  output logic                    scrub_busy,
  output logic                    scrub_done,
  output logic                    scrub_fatal,
  output logic [COUNT_WIDTH-1:0]  corrected_count
);

  scrub_state_t            r_state, w_next;
  logic [ADDRESS_SIZE-1:0] r_ptr;
  logic [WIDTH_SIZE-1:0]   r_a, r_b, r_c;
  logic [WIDTH_SIZE-1:0]   w_voted;
  logic                    r_fatal;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    w_mismatch, w_fatal;
  logic                    w_user_wr, w_collide, w_scrub_wr, w_start, w_auto_start;

  tmr_vote_check #(.WIDTH(WIDTH_SIZE)) u_vote (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_c       (r_c),
    .o_voted   (w_voted),
    .o_mismatch(w_mismatch),
    .o_fatal   (w_fatal)
  );

`ifdef SCRUB_PERIODIC_EN
  localparam int PW = $clog2(SCRUB_PERIOD + 1);
  logic [PW-1:0] r_period_cnt;

  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      r_period_cnt <= '0;
    end else if (r_state != S_IDLE || w_auto_start) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  assign w_auto_start = (r_state == S_IDLE) && (r_period_cnt == PW'(SCRUB_PERIOD - 1));
`else
  // Constant 0: without the counter only scrub_start begins a pass.
  assign w_auto_start = (SCRUB_PERIOD < 0);
`endif

  assign w_start   = scrub_start | w_auto_start;
  assign w_user_wr = write_enable & ~write_full;
  // A user write to the scrubbed word carries newer data, so the writeback is dropped.
  assign w_collide = w_user_wr && (write_address == r_ptr);

  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_scrub_wr = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_RD;
      S_RD:   w_next = S_CMP;
      S_CMP:  w_next = (w_mismatch && !w_fatal && !w_collide) ? S_WB : S_ADV;
      S_WB: begin
        w_scrub_wr = !w_user_wr && !scrub_abort;
        if (w_scrub_wr || w_collide) w_next = S_ADV;
      end
      S_ADV:  w_next = (r_ptr == '1) ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (scrub_abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      r_ptr   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_fatal <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_ptr   <= '0;
          r_fatal <= 1'b0;
          r_count <= '0;
        end
        S_RD: begin
          r_a <= scrub_data1;
          r_b <= scrub_data2;
          r_c <= scrub_data3;
        end
        S_CMP: if (w_fatal) r_fatal <= 1'b1;
        S_WB:  if (w_scrub_wr && r_count != '1) r_count <= r_count + 1'b1;
        S_ADV: if (r_ptr != '1) r_ptr <= r_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_write_enable  = w_scrub_wr ? 1'b1    : write_enable;
  assign mem_write_full    = w_scrub_wr ? 1'b0    : write_full;
  assign mem_write_address = w_scrub_wr ? r_ptr   : write_address;
  assign mem_write_data    = w_scrub_wr ? w_voted : write_data;

  assign scrub_address   = r_ptr;
  assign scrub_busy      = (r_state != S_IDLE);
  assign scrub_done      = (r_state == S_DONE);
  assign scrub_fatal     = r_fatal;
  assign corrected_count = r_count;

endmodule

// File: tb/tb_fifo_tmr_scrubber.sv
// tb/tb_fifo_tmr_scrubber.sv - directed self-checking bench for fifo_tmr_scrubber
module tb_fifo_tmr_scrubber;

  localparam int W = 8;
  localparam int A = 4;
  localparam int C = 16;
  localparam int D = 1 << A;

  logic         write_clk = 1'b0;
  logic         write_reset;
  logic         write_enable;
  logic         write_full;
  logic [A-1:0] write_address;
  logic [W-1:0] write_data;
  logic         scrub_start;
  logic         scrub_abort;
  logic [A-1:0] scrub_address;
  logic [W-1:0] scrub_data1, scrub_data2, scrub_data3;
  logic         mem_write_enable;
  logic         mem_write_full;
  logic [A-1:0] mem_write_address;
  logic [W-1:0] mem_write_data;
  logic         scrub_busy;
  logic         scrub_done;
  logic         scrub_fatal;
  logic [C-1:0] corrected_count;

  logic [W-1:0] mem [0:2][0:D-1];
  logic         poke_en = 1'b0;
  int           poke_copy = 0;
  logic [A-1:0] poke_addr = '0;
  logic [W-1:0] poke_data = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_swr = 0;
  int done_cyc = 0;
  int t0, base_done, base_swr;

  fifo_tmr_scrubber #(
    .WIDTH_SIZE  (W),
    .ADDRESS_SIZE(A),
    .COUNT_WIDTH (C),
    .SCRUB_PERIOD(1000)
  ) dut (
    .write_clk        (write_clk),
    .write_reset      (write_reset),
    .write_enable     (write_enable),
    .write_full       (write_full),
    .write_address    (write_address),
    .write_data       (write_data),
    .scrub_start      (scrub_start),
    .scrub_abort      (scrub_abort),
    .scrub_address    (scrub_address),
    .scrub_data1      (scrub_data1),
    .scrub_data2      (scrub_data2),
    .scrub_data3      (scrub_data3),
    .mem_write_enable (mem_write_enable),
    .mem_write_full   (mem_write_full),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .scrub_busy       (scrub_busy),
    .scrub_done       (scrub_done),
    .scrub_fatal      (scrub_fatal),
    .corrected_count  (corrected_count)
  );

  initial forever #5 write_clk = ~write_clk;

  assign scrub_data1 = mem[0][scrub_address];
  assign scrub_data2 = mem[1][scrub_address];
  assign scrub_data3 = mem[2][scrub_address];

  always @(posedge write_clk) begin
    cyc <= cyc + 1;
    if (write_reset) begin
      for (int c = 0; c < 3; c++)
        for (int a = 0; a < D; a++) mem[c][a] <= '0;
    end else begin
      if (mem_write_enable && !mem_write_full)
        for (int c = 0; c < 3; c++) mem[c][mem_write_address] <= mem_write_data;
      if (poke_en) mem[poke_copy][poke_addr] <= poke_data;
    end
  end

  always @(negedge write_clk) begin
    if (!write_reset) begin
      if (scrub_done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
      if (mem_write_enable && !mem_write_full && !(write_enable && !write_full))
        n_swr <= n_swr + 1;
    end
  end

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int copy, input logic [A-1:0] addr, input logic [W-1:0] data);
    poke_copy = copy;
    poke_addr = addr;
    poke_data = data;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic start_pass();
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    t0        = cyc;
    base_done = n_done;
    base_swr  = n_swr;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (scrub_busy && k < 300) begin
      tick();
      k++;
    end
    check({tag, "_busy_end"}, scrub_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    write_reset   = 1'b1;
    write_enable  = 1'b0;
    write_full    = 1'b0;
    write_address = '0;
    write_data    = '0;
    scrub_start   = 1'b0;
    scrub_abort   = 1'b0;
    repeat (3) tick();
    write_reset = 1'b0;
    tick();

    check("rst_busy", scrub_busy, 0);
    check("rst_done", scrub_done, 0);
    check("rst_fatal", scrub_fatal, 0);
    check("rst_count", corrected_count, 0);
    check("rst_saddr", scrub_address, 0);
    check("rst_mwe", mem_write_enable, 0);

    // Clean pass: 16 addresses x 3 cycles, DONE after edge 48, idle after edge 49.
    start_pass();
    check("clean_busy", scrub_busy, 1);
    wait_idle("clean");
    check("clean_done_at", done_cyc - t0, 48);
    check("clean_len", cyc - t0, 49);
    check("clean_ndone", n_done - base_done, 1);
    check("clean_swr", n_swr - base_swr, 0);
    check("clean_count", corrected_count, 0);

    // Single-copy upset at address 5: WB is the cycle after edge 17.
    poke(1, 4'd5, 8'hFF);
    start_pass();
    repeat (17) tick();
    check("fix5_we", mem_write_enable, 1);
    check("fix5_full", mem_write_full, 0);
    check("fix5_addr", mem_write_address, 5);
    check("fix5_data", mem_write_data, 8'h00);
    wait_idle("fix5");
    check("fix5_len", cyc - t0, 50);
    check("fix5_swr", n_swr - base_swr, 1);
    check("fix5_count", corrected_count, 1);
    check("fix5_fatal", scrub_fatal, 0);
    check("fix5_mem", mem[1][5], 8'h00);

    // Three distinct copies at address 7: fatal, no write.
    poke(0, 4'd7, 8'h01);
    poke(1, 4'd7, 8'h02);
    poke(2, 4'd7, 8'h04);
    start_pass();
    repeat (23) tick();
    check("fat7_fatal_mid", scrub_fatal, 1);
    check("fat7_we", mem_write_enable, 0);
    wait_idle("fat7");
    check("fat7_fatal_end", scrub_fatal, 1);
    check("fat7_len", cyc - t0, 49);
    check("fat7_swr", n_swr - base_swr, 0);
    check("fat7_count", corrected_count, 0);

    // New start clears fatal; abort in RD at address 9.
    start_pass();
    check("abrt_fatal_clr", scrub_fatal, 0);
    repeat (27) tick();
    check("abrt_saddr", scrub_address, 9);
    scrub_abort = 1'b1;
    tick();
    scrub_abort = 1'b0;
    check("abrt_busy", scrub_busy, 0);
    check("abrt_fatal_kept", scrub_fatal, 1);
    repeat (5) tick();
    check("abrt_ndone", n_done - base_done, 0);
    poke(0, 4'd7, 8'h00);
    poke(1, 4'd7, 8'h00);
    poke(2, 4'd7, 8'h00);

    // Upset at address 3 while user writes address 12 for 5 cycles.
    poke(0, 4'd3, 8'h5A);
    start_pass();
    repeat (10) tick();
    write_enable  = 1'b1;
    write_address = 4'd12;
    write_data    = 8'hC3;
    repeat (2) tick();
    check("cont_user_we", mem_write_enable, 1);
    check("cont_user_addr", mem_write_address, 12);
    check("cont_user_data", mem_write_data, 8'hC3);
    repeat (3) tick();
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    #1;
    check("cont_scrub_we", mem_write_enable, 1);
    check("cont_scrub_addr", mem_write_address, 3);
    check("cont_scrub_data", mem_write_data, 8'h00);
    wait_idle("cont");
    check("cont_len", cyc - t0, 54);
    check("cont_swr", n_swr - base_swr, 1);
    check("cont_count", corrected_count, 1);
    check("cont_mem12", mem[2][12], 8'hC3);
    check("cont_mem3", mem[0][3], 8'h00);

    // User write to address 3 while WB at address 3: writeback cancelled.
    poke(0, 4'd3, 8'h5A);
    start_pass();
    repeat (11) tick();
    write_enable  = 1'b1;
    write_address = 4'd3;
    write_data    = 8'h77;
    #1;
    check("coll_addr", mem_write_address, 3);
    check("coll_data", mem_write_data, 8'h77);
    tick();
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    wait_idle("coll");
    check("coll_len", cyc - t0, 50);
    check("coll_count", corrected_count, 0);
    check("coll_swr", n_swr - base_swr, 0);
    check("coll_mem0", mem[0][3], 8'h77);
    check("coll_mem1", mem[1][3], 8'h77);

    // Reset asserted while a writeback is pending at address 4.
    poke(1, 4'd4, 8'h11);
    start_pass();
    repeat (14) tick();
    check("rwb_we_pre", mem_write_enable, 1);
    check("rwb_addr_pre", mem_write_address, 4);
    write_reset = 1'b1;
    #1;
    check("rwb_busy", scrub_busy, 0);
    check("rwb_done", scrub_done, 0);
    check("rwb_fatal", scrub_fatal, 0);
    check("rwb_count", corrected_count, 0);
    check("rwb_saddr", scrub_address, 0);
    check("rwb_we", mem_write_enable, 0);
    check("rwb_addr", mem_write_address, 0);
    check("rwb_data", mem_write_data, 0);
    repeat (2) tick();
    write_reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
